// File: rtl/loop_pkg.sv
// Shared definitions for the bracket-loop controller: FSM states, bracket opcodes, fault causes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package loop_pkg;

    // Bracket opcodes (ASCII)
    localparam logic [7:0] OP_OPEN  = 8'h5B;  // '['
    localparam logic [7:0] OP_CLOSE = 8'h5D;  // ']'

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SKIP   = 2'd1,
        ST_BRANCH = 2'd2,
        ST_ERROR  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_OVF      = 2'd1,
        ERR_UNF      = 2'd2,
        ERR_SKIP_OVF = 2'd3
    } err_code_e;

endpackage

// File: rtl/loop_ctrl.sv
// Loop controller: resolves '[' / ']' against a parent-owned return stack, skips zero-cell loop bodies.
// Latency: stack strobes and exec_en are combinational on accept; a taken ']' redirects one cycle later.
// Backpressure: instr_ready drops for the one redirect cycle and permanently in ERROR until reset.
module loop_ctrl
    import loop_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int SKIP_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [7:0]      instr,
    input  logic [PC_W-1:0] instr_pc,
    input  logic            cell_zero,
    output logic            instr_ready,
    output logic            exec_en,
    output logic            br_valid,
    output logic [PC_W-1:0] br_target,
    output logic            stk_push,
    output logic            stk_pop,
    output logic [PC_W-1:0] stk_din,
    input  logic [PC_W-1:0] stk_dout,
    input  logic            stk_empty,
    input  logic            stk_full,
    output logic            err,
    output logic [1:0]      err_code
);

    localparam logic [SKIP_W-1:0] DEPTH_MAX = {SKIP_W{1'b1}};
    localparam logic [SKIP_W-1:0] DEPTH_ONE = SKIP_W'(1);

    state_e            state;
    err_code_e         err_code_q;
    logic [SKIP_W-1:0] depth;

    logic accept;
    logic is_open;
    logic is_close;
    logic in_run;

    assign is_open  = (instr == OP_OPEN);
    assign is_close = (instr == OP_CLOSE);
    assign in_run   = (state == ST_RUN);

    // Ready only in RUN/SKIP; held low during reset so nothing is accepted while it is asserted.
    assign instr_ready = !reset && (state == ST_RUN || state == ST_SKIP);
    assign accept      = instr_valid && instr_ready;

    // Same-cycle strobes to the stack and datapath; faulting brackets produce none of them.
    assign stk_push = accept && in_run && is_open  && !cell_zero && !stk_full;
    assign stk_pop  = accept && in_run && is_close && !stk_empty &&  cell_zero;
    assign stk_din  = stk_push ? instr_pc : '0;
    assign exec_en  = accept && in_run && !is_open && !is_close;

    assign err_code = err_code_q;

    // FSM with registered redirect/fault outputs and forward-skip nesting depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RUN;
            depth      <= '0;
            br_valid   <= 1'b0;
            br_target  <= '0;
            err        <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            br_valid <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (accept && is_open) begin
                        if (cell_zero) begin
                            depth <= DEPTH_ONE;
                            state <= ST_SKIP;
                        end else if (stk_full) begin
                            err        <= 1'b1;
                            err_code_q <= ERR_OVF;
                            state      <= ST_ERROR;
                        end
                    end else if (accept && is_close) begin
                        if (stk_empty) begin
                            err        <= 1'b1;
                            err_code_q <= ERR_UNF;
                            state      <= ST_ERROR;
                        end else if (!cell_zero) begin
                            // Jump to the instruction just after the matching '['
                            br_target <= stk_dout + PC_W'(1);
                            br_valid  <= 1'b1;
                            state     <= ST_BRANCH;
                        end
                    end
                end
                ST_SKIP: begin
                    if (accept && is_open) begin
                        if (depth == DEPTH_MAX) begin
                            err        <= 1'b1;
                            err_code_q <= ERR_SKIP_OVF;
                            state      <= ST_ERROR;
                        end else begin
                            depth <= depth + DEPTH_ONE;
                        end
                    end else if (accept && is_close) begin
                        depth <= depth - DEPTH_ONE;
                        if (depth == DEPTH_ONE) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_BRANCH: begin
                    state <= ST_RUN;
                end
                default: begin
                    // ST_ERROR: everything frozen until reset
                    state <= ST_ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loop_ctrl.sv
// Directed bench for loop_ctrl: loop fall-through, taken branch, forward skip, faults and reset.
// Latency: combinational outputs sampled 1 ns after input drive, registered ones 1 ns after posedge.
// Backpressure: instr_valid is held during non-ready cycles to prove nothing is accepted.
module tb_loop_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       cell_zero;
    logic       instr_ready;
    logic       exec_en;
    logic       br_valid;
    logic [7:0] br_target;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_din;
    logic [7:0] stk_dout;
    logic       stk_empty;
    logic       stk_full;
    logic       err;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    loop_ctrl #(.PC_W(8), .SKIP_W(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .cell_zero  (cell_zero),
        .instr_ready(instr_ready),
        .exec_en    (exec_en),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .stk_push   (stk_push),
        .stk_pop    (stk_pop),
        .stk_din    (stk_din),
        .stk_dout   (stk_dout),
        .stk_empty  (stk_empty),
        .stk_full   (stk_full),
        .err        (err),
        .err_code   (err_code)
    );

    // Drive one instruction at the falling edge, then settle before sampling.
    task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] pc, input logic cz);
        @(negedge clk);
        instr_valid = v;
        instr       = op;
        instr_pc    = pc;
        cell_zero   = cz;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        instr_valid = 1'b0;
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; instr_valid = 1'b1; instr = 8'h5B; instr_pc = 8'h07; cell_zero = 1'b0;
        stk_empty = 1'b0; stk_full = 1'b0; stk_dout = 8'h00;
        #1;
        n_checks++; if (stk_push !== 1'b0) begin n_fail++; $display("FAIL rst_push got=%b exp=0", stk_push); end
        n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", instr_ready); end
        tick();
        n_checks++; if ({br_valid, err, err_code} !== 4'b0) begin n_fail++; $display("FAIL rst_regs got=%b exp=0000", {br_valid, err, err_code}); end
        n_checks++; if (br_target !== 8'h00) begin n_fail++; $display("FAIL rst_target got=%h exp=00", br_target); end
        @(negedge clk);
        reset = 1'b0; instr_valid = 1'b0;
        #1;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got=%b exp=1", instr_ready); end
    endtask

    // "+[-]" with the ']' seeing a zero cell: push at '[', pop at ']', no redirect.
    task automatic test_loop_exit();
        drive(1'b1, 8'h2B, 8'd0, 1'b0);
        n_checks++; if (exec_en !== 1'b1) begin n_fail++; $display("FAIL lx_exec_plus got=%b exp=1", exec_en); end
        tick();
        drive(1'b1, 8'h5B, 8'd1, 1'b0);
        n_checks++; if ({stk_push, stk_pop, exec_en} !== 3'b100) begin n_fail++; $display("FAIL lx_push got=%b exp=100", {stk_push, stk_pop, exec_en}); end
        n_checks++; if (stk_din !== 8'd1) begin n_fail++; $display("FAIL lx_din got=%h exp=01", stk_din); end
        tick();
        drive(1'b1, 8'h2D, 8'd2, 1'b0);
        n_checks++; if (exec_en !== 1'b1) begin n_fail++; $display("FAIL lx_exec_minus got=%b exp=1", exec_en); end
        tick();
        drive(1'b1, 8'h5D, 8'd3, 1'b1);
        n_checks++; if ({stk_push, stk_pop, exec_en} !== 3'b010) begin n_fail++; $display("FAIL lx_pop got=%b exp=010", {stk_push, stk_pop, exec_en}); end
        tick();
        n_checks++; if ({br_valid, instr_ready} !== 2'b01) begin n_fail++; $display("FAIL lx_nobranch got=%b exp=01", {br_valid, instr_ready}); end
    endtask

    // Taken ']' redirects to top-of-stack + 1, including wrap at the PC width.
    task automatic test_branch(input logic [7:0] tos, input logic [7:0] exp_tgt);
        stk_dout = tos;
        drive(1'b1, 8'h5D, 8'd9, 1'b0);
        n_checks++; if ({stk_push, stk_pop} !== 2'b00) begin n_fail++; $display("FAIL br_strobes got=%b exp=00", {stk_push, stk_pop}); end
        tick();
        n_checks++; if ({br_valid, instr_ready} !== 2'b10) begin n_fail++; $display("FAIL br_pulse got=%b exp=10", {br_valid, instr_ready}); end
        n_checks++; if (br_target !== exp_tgt) begin n_fail++; $display("FAIL br_target got=%h exp=%h", br_target, exp_tgt); end
        drive(1'b1, 8'h2B, 8'd10, 1'b0);
        n_checks++; if (exec_en !== 1'b0) begin n_fail++; $display("FAIL br_exec_stall got=%b exp=0", exec_en); end
        tick();
        n_checks++; if ({br_valid, instr_ready} !== 2'b01) begin n_fail++; $display("FAIL br_done got=%b exp=01", {br_valid, instr_ready}); end
    endtask

    // '[' on a zero cell then "[+]]": nested skip, nothing executed, back in RUN after.
    task automatic test_skip();
        drive(1'b1, 8'h5B, 8'd0, 1'b1);
        n_checks++; if (stk_push !== 1'b0) begin n_fail++; $display("FAIL sk_nopush got=%b exp=0", stk_push); end
        tick();
        drive(1'b1, 8'h5B, 8'd1, 1'b0);
        n_checks++; if ({stk_push, exec_en} !== 2'b00) begin n_fail++; $display("FAIL sk_inner_open got=%b exp=00", {stk_push, exec_en}); end
        tick();
        drive(1'b1, 8'h2B, 8'd2, 1'b0);
        n_checks++; if (exec_en !== 1'b0) begin n_fail++; $display("FAIL sk_exec got=%b exp=0", exec_en); end
        tick();
        drive(1'b1, 8'h5D, 8'd3, 1'b0);
        n_checks++; if ({stk_pop, exec_en} !== 2'b00) begin n_fail++; $display("FAIL sk_inner_close got=%b exp=00", {stk_pop, exec_en}); end
        tick();
        // Depth should be 1 here: a '+' must still be skipped
        drive(1'b1, 8'h2B, 8'd4, 1'b0);
        n_checks++; if (exec_en !== 1'b0) begin n_fail++; $display("FAIL sk_depth1 got=%b exp=0", exec_en); end
        tick();
        drive(1'b1, 8'h5D, 8'd5, 1'b0);
        tick();
        drive(1'b1, 8'h2B, 8'd6, 1'b0);
        n_checks++; if (exec_en !== 1'b1) begin n_fail++; $display("FAIL sk_back_run got=%b exp=1", exec_en); end
        tick();
    endtask

    task automatic test_underflow();
        stk_empty = 1'b1;
        drive(1'b1, 8'h5D, 8'd9, 1'b0);
        n_checks++; if ({stk_pop, exec_en} !== 2'b00) begin n_fail++; $display("FAIL uf_strobes got=%b exp=00", {stk_pop, exec_en}); end
        tick();
        stk_empty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h2B, 8'd10, 1'b0);
            n_checks++; if ({err, err_code, instr_ready, exec_en} !== 5'b11000) begin n_fail++; $display("FAIL uf_hold%0d got=%b exp=11000", i, {err, err_code, instr_ready, exec_en}); end
            tick();
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if ({instr_ready, exec_en, stk_push, stk_pop} !== 4'b0) begin n_fail++; $display("FAIL uf_rst_comb got=%b exp=0000", {instr_ready, exec_en, stk_push, stk_pop}); end
        tick();
        @(negedge clk);
        reset = 1'b0; instr_valid = 1'b0;
        #1;
        n_checks++; if ({err, err_code, br_valid, instr_ready} !== 5'b00001) begin n_fail++; $display("FAIL uf_after_rst got=%b exp=00001", {err, err_code, br_valid, instr_ready}); end
    endtask

    task automatic test_overflow();
        stk_full = 1'b1;
        drive(1'b1, 8'h5B, 8'd3, 1'b0);
        n_checks++; if (stk_push !== 1'b0) begin n_fail++; $display("FAIL ovf_push got=%b exp=0", stk_push); end
        tick();
        stk_full = 1'b0;
        n_checks++; if ({err, err_code, instr_ready} !== 4'b1010) begin n_fail++; $display("FAIL ovf_err got=%b exp=1010", {err, err_code, instr_ready}); end
        do_reset();
        // Enter SKIP, then reset while a ']' is offered: reset wins
        drive(1'b1, 8'h5B, 8'd0, 1'b1);
        tick();
        drive(1'b1, 8'h5B, 8'd1, 1'b1);
        tick();
        @(negedge clk);
        reset = 1'b1; instr = 8'h5D;
        tick();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 8'h2B, 8'd2, 1'b0);
        n_checks++; if (exec_en !== 1'b1) begin n_fail++; $display("FAIL ovf_skip_rst got=%b exp=1", exec_en); end
        tick();
        // Reset alongside a taken ']' must leave no redirect pulse
        stk_dout = 8'h20;
        @(negedge clk);
        reset = 1'b1; instr_valid = 1'b1; instr = 8'h5D; cell_zero = 1'b0;
        tick();
        @(negedge clk);
        reset = 1'b0; instr_valid = 1'b0;
        tick();
        n_checks++; if ({br_valid, br_target} !== 9'b0) begin n_fail++; $display("FAIL rst_no_branch got=%b exp=0", {br_valid, br_target}); end
    endtask

    // Nest the skip to the counter limit; one more '[' is a skip overflow.
    task automatic test_skip_ovf();
        drive(1'b1, 8'h5B, 8'd0, 1'b1);
        tick();
        for (int i = 0; i < 126; i++) begin
            drive(1'b1, 8'h5B, 8'd1, 1'b0);
            tick();
        end
        n_checks++; if ({err, instr_ready} !== 2'b01) begin n_fail++; $display("FAIL so_at_max got=%b exp=01", {err, instr_ready}); end
        drive(1'b1, 8'h5B, 8'd2, 1'b0);
        tick();
        n_checks++; if ({err, err_code} !== 3'b111) begin n_fail++; $display("FAIL so_err got=%b exp=111", {err, err_code}); end
        do_reset();
    endtask

    // Back-to-back pushes: each '[' pushes its own pc.
    task automatic test_back_to_back();
        drive(1'b1, 8'h5B, 8'd10, 1'b0);
        n_checks++; if ({stk_push, stk_din} !== {1'b1, 8'd10}) begin n_fail++; $display("FAIL b2b_push0 got=%b/%h exp=1/0a", stk_push, stk_din); end
        tick();
        drive(1'b1, 8'h5B, 8'd11, 1'b0);
        n_checks++; if ({stk_push, stk_din} !== {1'b1, 8'd11}) begin n_fail++; $display("FAIL b2b_push1 got=%b/%h exp=1/0b", stk_push, stk_din); end
        tick();
        drive(1'b0, 8'h5B, 8'd12, 1'b0);
        n_checks++; if (stk_push !== 1'b0) begin n_fail++; $display("FAIL b2b_novalid got=%b exp=0", stk_push); end
        tick();
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = 8'h00; instr_pc = 8'h00; cell_zero = 1'b0;
        stk_dout = 8'h00; stk_empty = 1'b0; stk_full = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_loop_exit();
        test_branch(8'h04, 8'h05);
        test_branch(8'hFF, 8'h00);
        test_skip();
        test_underflow();
        test_overflow();
        test_skip_ovf();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
